// File: rtl/mem_refill_arbiter_if.sv
// Bundles the I/D requester handshakes and the backing-memory beat channel.
// The slave modport is the arbiter's view; the master modport is the cache and memory side.
interface mem_refill_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 4
);
  localparam int BEAT_W = $clog2(BURST_LEN);

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [WIDTH-1:0]      d_wdata;
  logic                  i_gnt;
  logic                  d_gnt;
  logic [BEAT_W-1:0]     beat;
  logic [WIDTH-1:0]      rdata;
  logic                  i_rvalid;
  logic                  d_rvalid;
  logic                  i_done;
  logic                  d_done;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  mem_ack;
  logic [WIDTH-1:0]      mem_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_gnt, d_gnt, beat, rdata, i_rvalid, d_rvalid, i_done, d_done,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_gnt, d_gnt, beat, rdata, i_rvalid, d_rvalid, i_done, d_done,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Round-robin arbiter sharing one backing-memory channel between I-cache refills
// and D-cache refills/writebacks; each grant runs a full line burst of BURST_LEN beats.
module mem_refill_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input logic                clk,
  input logic                rst,
  mem_refill_arbiter_if.slave bus
);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BURST_LEN * 4 - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t                state_reg, state_next;
  logic                  owner_reg, owner_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] base_reg, base_next;
  logic [BEAT_W-1:0]     beat_reg, beat_next;
  logic                  last_owner_reg, last_owner_next;

  logic                  pick_d;
  logic                  in_burst;
  logic [1:0]            gnt_vec, rvalid_vec, done_vec;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_I;
      we_reg         <= 1'b0;
      base_reg       <= '0;
      beat_reg       <= '0;
      last_owner_reg <= OWN_I;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      we_reg         <= we_next;
      base_reg       <= base_next;
      beat_reg       <= beat_next;
      last_owner_reg <= last_owner_next;
    end
  end

  // D wins when alone, or on a tie when I had the channel last.
  assign pick_d = bus.d_req && (!bus.i_req || (last_owner_reg == OWN_I));

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    we_next         = we_reg;
    base_next       = base_reg;
    beat_next       = beat_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          owner_next = pick_d;
          we_next    = pick_d ? bus.d_we : 1'b0;
          base_next  = (pick_d ? bus.d_addr : bus.i_addr) & LINE_MASK;
          beat_next  = '0;
          state_next = BURST;
        end
      end
      BURST: begin
        if (bus.mem_ack) begin
          if (beat_reg == LAST_BEAT) begin
            beat_next       = '0;
            last_owner_next = owner_reg;
            state_next      = DONE;
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_burst = (state_reg == BURST);

  // Index 0 is the I requester, index 1 the D requester.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign gnt_vec[gi]    = in_burst && (owner_reg == 1'(gi));
    assign rvalid_vec[gi] = gnt_vec[gi] && !we_reg && bus.mem_ack;
    assign done_vec[gi]   = (state_reg == DONE) && (owner_reg == 1'(gi));
  end

  assign bus.i_gnt     = gnt_vec[0];
  assign bus.d_gnt     = gnt_vec[1];
  assign bus.i_rvalid  = rvalid_vec[0];
  assign bus.d_rvalid  = rvalid_vec[1];
  assign bus.i_done    = done_vec[0];
  assign bus.d_done    = done_vec[1];
  assign bus.beat      = beat_reg;
  assign bus.mem_req   = in_burst;
  assign bus.mem_we    = in_burst && we_reg;
  assign bus.mem_addr  = in_burst ? (base_reg + ADDR_WIDTH'({beat_reg, 2'b00})) : '0;
  assign bus.mem_wdata = (in_burst && (owner_reg == OWN_D) && we_reg) ? bus.d_wdata : '0;
  // Gated so the read bus is quiet outside read beats, including right after reset.
  assign bus.rdata     = (|rvalid_vec) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Self-checking bench for mem_refill_arbiter: a beat scoreboard fed by the scenario
// tasks is drained by a monitor whenever memory accepts a beat.
module tb_mem_refill_arbiter;
  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int BURST_LEN  = 4;

  typedef struct {
    logic        owner;  // 1 = D, 0 = I
    logic [31:0] addr;
    logic        we;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   ack_mode = 0;  // 0: ack every cycle, 1: ack every third cycle
  int   ack_cnt = 0;
  beat_t exp_q[$];
  logic exp_done_pend = 1'b0;
  logic exp_done_owner = 1'b0;

  always #5 clk = ~clk;

  mem_refill_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BURST_LEN(BURST_LEN)) bus ();

  mem_refill_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BURST_LEN(BURST_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model and writeback data source, updated on each falling edge.
  always @(negedge clk) begin
    ack_cnt       = (ack_cnt + 1) % 3;
    bus.mem_ack   = (ack_mode == 0) ? 1'b1 : (ack_cnt == 0);
    bus.mem_rdata = $urandom;
    bus.d_wdata   = $urandom;
  end

  // Monitor: samples 1 time unit after the falling edge, before the tasks act.
  always @(negedge clk) begin
    beat_t e;
    logic [1:0] exp_rv;
    #1;
    if (!rst) begin
      exp_q.delete();
      exp_done_pend = 1'b0;
    end else begin
      checks++;
      if (bus.i_gnt && bus.d_gnt) begin
        failures++;
        $display("FAIL gnt_mutex: i_gnt=%b d_gnt=%b required not both", bus.i_gnt, bus.d_gnt);
      end
      if (exp_done_pend) begin
        checks++;
        if ({bus.i_done, bus.d_done} !== (exp_done_owner ? 2'b01 : 2'b10)) begin
          failures++;
          $display("FAIL done_pulse: {i_done,d_done}=%b required %b", {bus.i_done, bus.d_done},
                   exp_done_owner ? 2'b01 : 2'b10);
        end
        exp_done_pend = 1'b0;
      end else if (bus.i_done || bus.d_done) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: {i_done,d_done}=%b required 00", {bus.i_done, bus.d_done});
      end
      if (bus.mem_req && bus.mem_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: mem_addr=%0h with no beat outstanding", bus.mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.mem_addr !== e.addr) begin
            failures++;
            $display("FAIL beat_addr: mem_addr=%0h required %0h", bus.mem_addr, e.addr);
          end
          checks++;
          if (bus.mem_we !== e.we) begin
            failures++;
            $display("FAIL beat_we: mem_we=%b required %b", bus.mem_we, e.we);
          end
          checks++;
          if ({bus.d_gnt, bus.i_gnt} !== (e.owner ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL beat_owner: {d_gnt,i_gnt}=%b required %b", {bus.d_gnt, bus.i_gnt},
                     e.owner ? 2'b10 : 2'b01);
          end
          exp_rv = e.we ? 2'b00 : (e.owner ? 2'b10 : 2'b01);
          checks++;
          if ({bus.d_rvalid, bus.i_rvalid} !== exp_rv) begin
            failures++;
            $display("FAIL beat_rvalid: {d_rvalid,i_rvalid}=%b required %b",
                     {bus.d_rvalid, bus.i_rvalid}, exp_rv);
          end
          checks++;
          if (!e.we) begin
            if (bus.rdata !== bus.mem_rdata) begin
              failures++;
              $display("FAIL beat_rdata: rdata=%0h required %0h", bus.rdata, bus.mem_rdata);
            end
          end else if (bus.mem_wdata !== bus.d_wdata) begin
            failures++;
            $display("FAIL beat_wdata: mem_wdata=%0h required %0h", bus.mem_wdata, bus.d_wdata);
          end
          if (e.last) begin
            exp_done_pend  = 1'b1;
            exp_done_owner = e.owner;
          end
        end
      end else begin
        checks++;
        if ({bus.d_rvalid, bus.i_rvalid} !== 2'b00) begin
          failures++;
          $display("FAIL rvalid_idle: {d_rvalid,i_rvalid}=%b required 00",
                   {bus.d_rvalid, bus.i_rvalid});
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic push_burst(input logic owner, input logic [31:0] addr, input logic we);
    beat_t b;
    for (int k = 0; k < BURST_LEN; k++) begin
      b.owner = owner;
      b.addr  = (addr & ~32'(BURST_LEN * 4 - 1)) + 32'(k * 4);
      b.we    = we;
      b.last  = (k == BURST_LEN - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.i_addr = '0;  bus.d_addr = '0;
    repeat (3) cyc();
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done,
         bus.mem_req, bus.mem_we} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl: control outputs=%b required 00000000",
               {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done,
                bus.mem_req, bus.mem_we});
    end
    checks++;
    if ({bus.beat, bus.mem_addr, bus.mem_wdata, bus.rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data: beat=%0h mem_addr=%0h mem_wdata=%0h rdata=%0h required all 0",
               bus.beat, bus.mem_addr, bus.mem_wdata, bus.rdata);
    end
    rst = 1'b1;
    cyc();
    checks++;
    if (bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: mem_req=%b required 0", bus.mem_req);
    end
  endtask

  task automatic test_single_read();
    int nbeat = 0, nrv = 0, igs = 0, last_c = -1, done_c = -1;
    logic [31:0] addrs[BURST_LEN];
    ack_mode = 0;
    bus.d_addr = 32'h1234; bus.d_we = 1'b0; bus.d_req = 1'b1;
    push_burst(1'b1, 32'h1234, 1'b0);
    cyc();
    checks++;
    if ({bus.d_gnt, bus.mem_req} !== 2'b11) begin
      failures++;
      $display("FAIL read_latency: {d_gnt,mem_req}=%b required 11", {bus.d_gnt, bus.mem_req});
    end
    for (int c = 0; c < 20 && done_c < 0; c++) begin
      if (c > 0) cyc();
      if (bus.mem_req && bus.mem_ack) begin
        if (nbeat < BURST_LEN) addrs[nbeat] = bus.mem_addr;
        nbeat++;
        last_c = c;
      end
      if (bus.d_rvalid) nrv++;
      if (bus.i_gnt) igs++;
      if (bus.d_done) begin
        done_c = c;
        bus.d_req = 1'b0;
      end
    end
    checks++;
    if (nbeat !== BURST_LEN || last_c !== BURST_LEN - 1) begin
      failures++;
      $display("FAIL read_beats: beats=%0d last_cycle=%0d required %0d and %0d",
               nbeat, last_c, BURST_LEN, BURST_LEN - 1);
    end
    for (int k = 0; k < BURST_LEN && k < nbeat; k++) begin
      checks++;
      if (addrs[k] !== 32'h1230 + 32'(k * 4)) begin
        failures++;
        $display("FAIL read_addr_seq: beat %0d addr=%0h required %0h", k, addrs[k],
                 32'h1230 + 32'(k * 4));
      end
    end
    checks++;
    if (nrv !== BURST_LEN || igs !== 0) begin
      failures++;
      $display("FAIL read_rvalid: d_rvalid cycles=%0d i_gnt cycles=%0d required %0d and 0",
               nrv, igs, BURST_LEN);
    end
    checks++;
    if (done_c !== last_c + 1) begin
      failures++;
      $display("FAIL read_done_time: d_done cycle=%0d required %0d", done_c, last_c + 1);
    end
    cyc();
    checks++;
    if (bus.d_gnt !== 1'b0) begin
      failures++;
      $display("FAIL read_release: d_gnt=%b required 0", bus.d_gnt);
    end
  endtask

  task automatic test_alternation();
    int ndone = 0, first_i = -1, first_dd = -1;
    logic [3:0] order = '0;
    ack_mode = 0;
    rst = 1'b0;
    bus.d_addr = 32'h2000; bus.i_addr = 32'h3004; bus.d_we = 1'b0;
    bus.d_req = 1'b1; bus.i_req = 1'b1;
    cyc();
    rst = 1'b1;
    push_burst(1'b1, 32'h2000, 1'b0);
    push_burst(1'b0, 32'h3004, 1'b0);
    push_burst(1'b1, 32'h2000, 1'b0);
    push_burst(1'b0, 32'h3004, 1'b0);
    for (int c = 0; c < 60 && ndone < 4; c++) begin
      cyc();
      if (bus.i_gnt && first_i < 0) first_i = c;
      if (bus.d_done && first_dd < 0) first_dd = c;
      if (bus.i_done || bus.d_done) begin
        order[ndone] = bus.d_done;
        ndone++;
        if (ndone == 4) begin
          bus.d_req = 1'b0;
          bus.i_req = 1'b0;
        end
      end
    end
    checks++;
    if (ndone !== 4 || order !== 4'b0101) begin
      failures++;
      $display("FAIL alt_order: bursts=%0d order(bit=D)=%b required 4 and 0101", ndone, order);
    end
    checks++;
    if (first_dd < 0 || first_i !== first_dd + 2) begin
      failures++;
      $display("FAIL alt_gap: first i_gnt cycle=%0d required %0d", first_i, first_dd + 2);
    end
    cyc();
  endtask

  task automatic test_writeback();
    int nack = 0, nrv = 0, gaps = 0, nwe = 0, nwd = 0;
    logic done = 1'b0;
    ack_mode = 1;
    bus.d_addr = 32'h4008; bus.d_we = 1'b1; bus.d_req = 1'b1;
    push_burst(1'b1, 32'h4008, 1'b1);
    for (int c = 0; c < 60 && !done; c++) begin
      cyc();
      if (bus.d_gnt) begin
        if (!bus.mem_req) gaps++;
        if (!bus.mem_we) nwe++;
        if (bus.mem_wdata !== bus.d_wdata) nwd++;
      end
      if (bus.mem_req && bus.mem_ack) nack++;
      if (bus.d_rvalid) nrv++;
      if (bus.d_done) begin
        done = 1'b1;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
      end
    end
    checks++;
    if (!done || nack !== BURST_LEN) begin
      failures++;
      $display("FAIL wb_acks: done=%b acks=%0d required 1 and %0d", done, nack, BURST_LEN);
    end
    checks++;
    if (nrv !== 0 || gaps !== 0 || nwe !== 0 || nwd !== 0) begin
      failures++;
      $display("FAIL wb_channel: rvalid=%0d req_gaps=%0d we_low=%0d wdata_bad=%0d required all 0",
               nrv, gaps, nwe, nwd);
    end
    ack_mode = 0;
    cyc();
  endtask

  task automatic test_i_during_d();
    int first_i = -1, dd_c = -1, nirv = 0;
    logic idone = 1'b0;
    ack_mode = 0;
    bus.d_addr = 32'h5010; bus.d_we = 1'b0; bus.d_req = 1'b1;
    push_burst(1'b1, 32'h5010, 1'b0);
    cyc();
    bus.i_addr = 32'h80; bus.i_req = 1'b1;
    push_burst(1'b0, 32'h80, 1'b0);
    for (int c = 0; c < 40 && !idone; c++) begin
      cyc();
      if (bus.i_gnt && first_i < 0) first_i = c;
      if (bus.d_done) begin
        dd_c = c;
        bus.d_req = 1'b0;
      end
      if (bus.i_rvalid) nirv++;
      if (bus.i_done) begin
        idone = 1'b1;
        bus.i_req = 1'b0;
      end
    end
    checks++;
    if (dd_c < 0 || first_i !== dd_c + 2) begin
      failures++;
      $display("FAIL i_wait: first i_gnt cycle=%0d required %0d", first_i, dd_c + 2);
    end
    checks++;
    if (!idone || nirv !== BURST_LEN) begin
      failures++;
      $display("FAIL i_refill: i_done=%b i_rvalid cycles=%0d required 1 and %0d",
               idone, nirv, BURST_LEN);
    end
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    int nack = 0;
    int first_owner = -1;
    logic ddone = 1'b0, idone = 1'b0, bad_order = 1'b0;
    ack_mode = 0;
    bus.i_addr = 32'h100; bus.i_req = 1'b1;
    push_burst(1'b0, 32'h100, 1'b0);
    for (int c = 0; c < 20 && nack < 3; c++) begin
      cyc();
      if (bus.mem_req && bus.mem_ack) nack++;
    end
    checks++;
    if (nack !== 3) begin
      failures++;
      $display("FAIL mid_reach: acks before reset=%0d required 3", nack);
    end
    rst = 1'b0;
    bus.d_addr = 32'h6000; bus.d_we = 1'b0; bus.d_req = 1'b1;
    cyc();
    checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done,
         bus.mem_req, bus.mem_we} !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_ctrl: control outputs=%b required 00000000",
               {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done,
                bus.mem_req, bus.mem_we});
    end
    checks++;
    if ({bus.beat, bus.mem_addr, bus.mem_wdata, bus.rdata} !== '0) begin
      failures++;
      $display("FAIL mid_reset_data: beat=%0h mem_addr=%0h mem_wdata=%0h rdata=%0h required all 0",
               bus.beat, bus.mem_addr, bus.mem_wdata, bus.rdata);
    end
    rst = 1'b1;
    push_burst(1'b1, 32'h6000, 1'b0);
    push_burst(1'b0, 32'h100, 1'b0);
    for (int c = 0; c < 40 && !idone; c++) begin
      cyc();
      if (first_owner < 0 && (bus.i_gnt || bus.d_gnt)) first_owner = bus.d_gnt ? 1 : 0;
      if (bus.d_done) begin
        ddone = 1'b1;
        bus.d_req = 1'b0;
      end
      if (bus.i_done) begin
        if (!ddone) bad_order = 1'b1;
        idone = 1'b1;
        bus.i_req = 1'b0;
      end
    end
    checks++;
    if (first_owner !== 1 || bad_order || !idone) begin
      failures++;
      $display("FAIL mid_regrant: first owner(1=D)=%0d i_before_d=%b i_done=%b required 1, 0, 1",
               first_owner, bad_order, idone);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternation();
    test_writeback();
    test_i_during_d();
    test_reset_mid_burst();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d beats outstanding required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Shares one single-ported backing-memory channel between two requesters: the instruction-cache refill path (I, read-only) and the data-cache refill/writeback path (D, read or write).
- Each granted transaction is a full cache-line burst of BURST_LEN words. Arbitration is round-robin.
- Sits between the cache controllers and main memory. Requesters hold their pipeline stall (miss_stall) until they see their done pulse.

Parameters:
- WIDTH, 32, data word width.
- ADDR_WIDTH, 32, byte address width.
- BURST_LEN, 4, words per line; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- i_req  in  1  I refill request; held until i_done
- i_addr  in  ADDR_WIDTH  I miss byte address
- d_req  in  1  D request; held until d_done
- d_we  in  1  D transaction is a writeback (1) or a refill (0)
- d_addr  in  ADDR_WIDTH  D line byte address
- d_wdata  in  WIDTH  writeback word for the current beat index
- i_gnt  out  1  I owns the channel
- d_gnt  out  1  D owns the channel
- beat  out  log2(BURST_LEN)  current beat index
- rdata  out  WIDTH  read word; equals mem_rdata
- i_rvalid  out  1  rdata valid for I this cycle
- d_rvalid  out  1  rdata valid for D this cycle
- i_done  out  1  one-cycle pulse: I burst complete
- d_done  out  1  one-cycle pulse: D burst complete
- mem_req  out  1  beat request to memory
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_WIDTH  beat byte address
- mem_wdata  out  WIDTH  write data
- mem_ack  in  1  memory accepts/completes the beat this cycle
- mem_rdata  in  WIDTH  read data; valid when mem_ack

Behaviour:
- States: IDLE, BURST, DONE. Registers: state, owner (I/D), we_q, base address, beat counter, last_owner.
- Reset (rst=0 at a clock edge, in any state including mid-burst):
  - state goes to IDLE, beat to 0, last_owner to I, so D wins the first tie.
  - All outputs read 0 in the cycle after the reset edge.
  - An in-flight memory beat is abandoned; no done pulse is issued.
- IDLE:
  - Only D requesting: owner=D.
  - Only I requesting: owner=I.
  - Both requesting: owner is the requester that is not last_owner.
  - On any grant: latch base = addr with bits [log2(BURST_LEN*4)-1:0] cleared, latch we_q (d_we for D, 0 for I), beat=0, go to BURST next cycle.
  - Latency: a request sampled at edge n makes gnt and mem_req high from cycle n+1.
- BURST:
  - Outputs: gnt of owner=1, mem_req=1, mem_we=we_q, mem_addr=base+beat*4, mem_wdata=d_wdata when owner=D and we_q=1, else 0.
  - Requests from the other requester are ignored, and its address is not sampled.
  - mem_req stays high until mem_ack. mem_ack may arrive in the same cycle mem_req rises.
  - On mem_ack with we_q=0: owner's rvalid=1 that cycle, rdata=mem_rdata (combinational).
  - On mem_ack with beat<BURST_LEN-1: beat increments and the next beat is issued the following cycle.
  - On mem_ack with beat=BURST_LEN-1: go to DONE, last_owner=owner.
  - With mem_ack tied high, throughput is one beat per cycle. Beats never wrap or skip, and addresses are strictly ascending.
- DONE (one cycle):
  - Owner's done=1; gnt=0, mem_req=0.
  - Requests are ignored this cycle; the requester drops req on seeing done.
  - Next state IDLE, which may re-grant the next cycle.
- A request still high in DONE is not re-granted until IDLE. The minimum gap between bursts is one DONE cycle plus one IDLE cycle.
- i_gnt and d_gnt are never high together. rvalid is never high for a write, nor outside BURST.
- Reset arbitration is the only priority. After that, strict alternation applies whenever both requesters are pending.

Test Plan:
- Single D read, d_addr=0x1234, mem_ack=1 every cycle:
  - mem_addr = 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles.
  - d_rvalid high on 4 cycles; d_done the cycle after the last beat; i_gnt stays 0.
- After reset, i_req and d_req rise together:
  - D is granted first; I is granted two cycles after d_done.
  - With both re-requesting continuously, grant order is D, I, D, I.
- D writeback, d_we=1, mem_ack high only every third cycle:
  - mem_req stays high between acks; mem_we=1; each mem_wdata tracks d_wdata for the current beat.
  - d_rvalid never asserts; exactly 4 acks precede d_done.
- I refill with i_addr=0x80 during a D burst:
  - I is not granted until D's burst ends and the DONE cycle passes.
  - I burst addresses are 0x80–0x8C; i_rvalid carries mem_rdata values.
- rst=0 pulsed at beat 2 of an I burst:
  - Next cycle all outputs are 0 and no i_done pulse occurs.
  - A pending simultaneous I/D request then grants D first.
